// File: rtl/mmio_data_responder_pkg.sv
// Shared definitions for the MMIO data responder: the register map,
// STATUS bit layout, default sizes and the address decode helper.
package mmio_data_responder_pkg;

  localparam int DEFAULT_RAM_WORDS  = 64;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  localparam logic [31:0] ADDR_TXDATA = 32'h0000_1000;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_1004;
  localparam logic [31:0] ADDR_CYCLE  = 32'h0000_1008;

  localparam int STATUS_FULL_BIT  = 0;
  localparam int STATUS_EMPTY_BIT = 1;
  localparam int STATUS_COUNT_LSB = 2;
  localparam int STATUS_COUNT_W   = 3;
  localparam int STATUS_ERR_BIT   = 8;
  localparam int STATUS_OVF_BIT   = 9;

  typedef enum logic [2:0] {
    REGION_RAM,
    REGION_TXDATA,
    REGION_STATUS,
    REGION_CYCLE,
    REGION_UNMAPPED
  } region_e;

  // Decodes a word address (byte address bits [31:2]) into its target region.
  function automatic region_e decodeAddr(input logic [29:0] wordAddr);
    region_e region;
    if (wordAddr[29:6] == 24'h0)
      region = REGION_RAM;
    else if (wordAddr == ADDR_TXDATA[31:2])
      region = REGION_TXDATA;
    else if (wordAddr == ADDR_STATUS[31:2])
      region = REGION_STATUS;
    else if (wordAddr == ADDR_CYCLE[31:2])
      region = REGION_CYCLE;
    else
      region = REGION_UNMAPPED;
    return region;
  endfunction

endpackage

// File: rtl/mmio_data_responder_tx_fifo.sv
// Transmit byte FIFO. A pop is only honoured when the FIFO holds data, and a
// push into a full FIFO still succeeds when a pop frees a slot on the same edge.
module tx_fifo
  import mmio_data_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [7:0]    i_pushData,
  input  logic          i_pop,
  output logic [7:0]    o_head,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [CW-1:0] r_count;

  logic w_doPop;
  logic w_doPush;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Storage array is not reset; a write is suppressed while reset is high.
  always_ff @(posedge clk) begin
    if (!reset && w_doPush)
      r_mem[r_wrPtr] <= i_pushData;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + PW'(1);
      if (w_doPop)
        r_rdPtr <= r_rdPtr + PW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_data_responder.sv
// Memory-mapped responder for a simple core bus: a word RAM, a transmit FIFO
// fed through TXDATA, a STATUS register with sticky error flags and a
// free-running, loadable CYCLE counter.
module mmio_data_responder
  import mmio_data_responder_pkg::*;
#(
  parameter int RAM_WORDS  = DEFAULT_RAM_WORDS,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_cycle;
  logic        r_errSticky;
  logic        r_ovfSticky;

  region_e           w_region;
  logic [RAM_AW-1:0] w_ramIdx;
  logic              w_push;
  logic              w_pop;
  logic              w_overflow;
  logic [7:0]        w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_status;
  logic              w_unusedAddrBits;

  assign w_unusedAddrBits = ^A[1:0];
  assign w_region         = decodeAddr(A[31:2]);
  assign w_ramIdx         = A[2 +: RAM_AW];

  assign w_push     = WE && (w_region == REGION_TXDATA);
  assign w_pop      = tx_valid && tx_ready;
  assign w_overflow = w_push && w_full && !w_pop;

  assign tx_valid = !w_empty;
  assign tx_data  = w_empty ? 8'h00 : w_head;

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_txFifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pushData(WD[7:0]),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Assemble the STATUS word from the registered FIFO state and sticky flags.
  always_comb begin
    w_status                                          = 32'h0;
    w_status[STATUS_FULL_BIT]                         = w_full;
    w_status[STATUS_EMPTY_BIT]                        = w_empty;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W]      = STATUS_COUNT_W'(w_count);
    w_status[STATUS_ERR_BIT]                          = r_errSticky;
    w_status[STATUS_OVF_BIT]                          = r_ovfSticky;
  end

  // Load data mux; TXDATA and unmapped addresses read back as zero.
  always_comb begin
    RD = 32'h0;
    case (w_region)
      REGION_RAM:    RD = r_ram[w_ramIdx];
      REGION_STATUS: RD = w_status;
      REGION_CYCLE:  RD = r_cycle;
      default:       RD = 32'h0;
    endcase
  end

  // RAM store port; contents survive reset but a store during reset is dropped.
  always_ff @(posedge clk) begin
    if (!reset && WE && (w_region == REGION_RAM))
      r_ram[w_ramIdx] <= WD;
  end

  // Cycle counter: a store replaces the value instead of incrementing.
  always_ff @(posedge clk) begin
    if (reset)
      r_cycle <= 32'h0;
    else if (WE && (w_region == REGION_CYCLE))
      r_cycle <= WD;
    else
      r_cycle <= r_cycle + 32'd1;
  end

  // Sticky error flags: set by the event, cleared by writing a one to STATUS.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errSticky <= 1'b0;
      r_ovfSticky <= 1'b0;
    end else begin
      if (WE && (w_region == REGION_UNMAPPED))
        r_errSticky <= 1'b1;
      else if (WE && (w_region == REGION_STATUS) && WD[STATUS_ERR_BIT])
        r_errSticky <= 1'b0;
      if (w_overflow)
        r_ovfSticky <= 1'b1;
      else if (WE && (w_region == REGION_STATUS) && WD[STATUS_OVF_BIT])
        r_ovfSticky <= 1'b0;
    end
  end

endmodule

// File: doc/mmio_data_responder.md
MMIO_DATA_RESPONDER -- requirements
Module: mmio_data_responder

Interface
REQ-001 Parameter RAM_WORDS, 64, number of 32-bit RAM words (power of two).
REQ-002 Parameter FIFO_DEPTH, 4, TX FIFO entries (power of two).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 WE  input  1  core store strobe; write takes effect at the rising edge.
REQ-006 A  input  32  core byte address; A[1:0] ignored.
REQ-007 WD  input  32  core store data.
REQ-008 RD  output  32  load data, combinational from A and current state.
REQ-009 tx_data  output  8  FIFO head byte; 8'h00 when FIFO empty.
REQ-010 tx_valid  output  1  high when FIFO non-empty.
REQ-011 tx_ready  input  1  downstream consumer accepts the head byte when high with tx_valid.

Function
REQ-012 Decode: RAM when A[31:8]==0, indexed by A[7:2]; TXDATA at 0x1000; STATUS at 0x1004; CYCLE at 0x1008; every other address is unmapped.
REQ-013 RAM: write WD to the word on WE; asynchronous read; a write becomes visible on RD from the cycle after the edge.
REQ-014 TXDATA write: push WD[7:0]; TXDATA read returns 32'h0.
REQ-015 STATUS read: bit0 full, bit1 empty, bits[4:2] count (0..FIFO_DEPTH), bit8 unmapped-write error, bit9 overflow; all other bits 0.
REQ-016 STATUS write: bit8 or bit9 set in WD clears the corresponding sticky bit; other bits ignored.
REQ-017 CYCLE: increments by 1 every cycle, wrapping 32'hFFFFFFFF -> 0; a write loads WD without incrementing that cycle; read returns current value.
REQ-018 Unmapped read returns 32'h0; unmapped write changes nothing except setting sticky bit8.
REQ-019 Pop occurs when tx_valid && tx_ready; head advances; tx_data shows the next entry from the following cycle.
REQ-020 Push when not full: byte enqueued at tail; count+1.
REQ-021 Push when full with no pop in the same cycle: byte dropped, count unchanged, sticky bit9 set.
REQ-022 Push and pop in the same cycle: both succeed, count unchanged, including when full (no overflow) and excluding when empty (pop impossible; push only).
REQ-023 Read/write pointers wrap modulo FIFO_DEPTH; FIFO order strictly first-in first-out.
REQ-024 Status bits and tx_valid derive from registered count; no combinational path from WE or tx_ready to tx_valid.

Reset
REQ-025 On reset at a rising edge: FIFO empty (pointers 0, count 0), CYCLE 0, bits 8 and 9 cleared.
REQ-026 After reset: tx_valid 0, tx_data 8'h00, STATUS reads 32'h0000_0002.
REQ-027 RAM contents are not reset.
REQ-028 Reset overrides any simultaneous write or pop; a mid-operation reset discards queued bytes.

Structure
REQ-029 Shared package holds address constants (TXDATA, STATUS, CYCLE), STATUS bit positions, default RAM_WORDS and FIFO_DEPTH.
REQ-030 FIFO is one sub-module, tx_fifo (push, push_data, pop, head, count, full, empty); decode, RAM, CYCLE and sticky bits stay in the top.

Verification
REQ-031 Store 0xDEADBEEF at A=0x10, then load A=0x10 -> RD=0xDEADBEEF; A=0x13 returns the same word.
REQ-032 With tx_ready=0, push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0000_0211 after the fifth push (full, count 4, overflow); then tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid 0.
REQ-033 FIFO full, tx_ready=1, push 0x55 in the same cycle -> no overflow, count stays 4, 0x55 is emitted last.
REQ-034 Write CYCLE=0xFFFFFFFE -> reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on the next three cycles.
REQ-035 Store to 0x2000 -> STATUS bit8=1 and load 0x2000 returns 0; write STATUS with 0x100 -> bit8=0.
REQ-036 Push two bytes, then assert reset for one cycle with tx_ready=1 -> tx_valid 0, tx_data 0x00, STATUS 0x0000_0002, CYCLE 0.
